gol_census: RTL and testbench

Multi-cycle, parametrised population census for the Game of Life board. On a `start` request it snapshots the current and previous generation vectors. It then counts live cells, births and deaths over `CHUNK` bits per cycle, and reports the results with a one-cycle `done` pulse. It also tracks stability and extinction across generations. It sits beside the generation engine and feeds the display/status logic.

---
 rtl/gol_pkg.sv | 21 ++
 rtl/gol_census_popcount_chunk.sv | 19 +
 rtl/gol_census.sv | 149 ++++++++++++++
 tb/tb_gol_census.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gol_pkg.sv
// Shared definitions for the Game of Life census: board defaults, FSM states
// and the counter-width helper.
package gol_pkg;

  localparam int DEF_ROWS   = 32;
  localparam int DEF_COLS   = 32;
  localparam int DEF_CHUNK  = 64;
  localparam int DEF_STAB_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    DONE
  } census_state_t;

  // Bits needed to hold any count from 0 to cells inclusive.
  function automatic int cntWidth(input int cells);
    return $clog2(cells + 1);
  endfunction

endpackage

// File: rtl/gol_census_popcount_chunk.sv
// Combinational population count of one CHUNK-bit slice of the board.
module popcount_chunk
  import gol_pkg::*;
#(
  parameter int CHUNK = DEF_CHUNK,
  localparam int OUT_W = cntWidth(CHUNK)
) (
  input  logic [CHUNK-1:0] i_bits,
  output logic [OUT_W-1:0] o_count
);

  always_comb begin
    o_count = '0;
    for (int i = 0; i < CHUNK; i++) begin
      o_count = o_count + OUT_W'(i_bits[i]);
    end
  end

endmodule

// File: rtl/gol_census.sv
// Multi-cycle census of live cells, births and deaths between two generations,
// plus extinction/stability tracking across successive censuses.
module gol_census
  import gol_pkg::*;
#(
  parameter int ROWS   = DEF_ROWS,
  parameter int COLS   = DEF_COLS,
  parameter int CHUNK  = DEF_CHUNK,
  parameter int STAB_W = DEF_STAB_W,
  localparam int N     = ROWS * COLS,
  localparam int CNT_W = cntWidth(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_clear,
  input  logic [N-1:0]      i_stateCur,
  input  logic [N-1:0]      i_statePrev,
  output logic              o_busy,
  output logic              o_done,
  output logic [CNT_W-1:0]  o_alives,
  output logic [CNT_W-1:0]  o_births,
  output logic [CNT_W-1:0]  o_deaths,
  output logic              o_extinct,
  output logic              o_stable,
  output logic [STAB_W-1:0] o_stableGens
);

  localparam int K     = (N + CHUNK - 1) / CHUNK;
  localparam int PAD_W = K * CHUNK;
  localparam int PC_W  = cntWidth(CHUNK);
  localparam int K_W   = (K > 1) ? $clog2(K) : 1;
  localparam logic [K_W-1:0]    K_LAST   = K_W'(K - 1);
  localparam logic [STAB_W-1:0] STAB_MAX = '1;

  census_state_t     r_state, w_nextState;
  logic [PAD_W-1:0]  r_snapCur, r_snapPrev;
  logic [K_W-1:0]    r_chunkIdx;
  logic [CNT_W-1:0]  r_accAlive, r_accBirth, r_accDeath;
  logic [CNT_W-1:0]  r_alives, r_births, r_deaths;
  logic              r_done, r_extinct, r_stable;
  logic [STAB_W-1:0] r_stableGens;
  logic [CHUNK-1:0]  w_chunkCur, w_chunkPrev;
  logic [PC_W-1:0]   w_pcAlive, w_pcBirth, w_pcDeath;
  logic              w_accept, w_countStep, w_finish, w_stableNow;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    w_countStep = 1'b0;
    w_finish    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_start) begin
          w_accept    = 1'b1;
          w_nextState = COUNT;
        end
      end
      COUNT: begin
        w_countStep = 1'b1;
        if (r_chunkIdx == K_LAST) w_nextState = DONE;
      end
      DONE: begin
        w_finish    = 1'b1;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // The low chunk of each snapshot is always the one being counted; padding
  // bits above N are zero in both snapshots so they add nothing.
  assign w_chunkCur  = r_snapCur[CHUNK-1:0];
  assign w_chunkPrev = r_snapPrev[CHUNK-1:0];

  popcount_chunk #(.CHUNK(CHUNK)) u_pcAlive (.i_bits(w_chunkCur),                .o_count(w_pcAlive));
  popcount_chunk #(.CHUNK(CHUNK)) u_pcBirth (.i_bits(w_chunkCur & ~w_chunkPrev), .o_count(w_pcBirth));
  popcount_chunk #(.CHUNK(CHUNK)) u_pcDeath (.i_bits(~w_chunkCur & w_chunkPrev), .o_count(w_pcDeath));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_snapCur  <= '0;
      r_snapPrev <= '0;
      r_chunkIdx <= '0;
      r_accAlive <= '0;
      r_accBirth <= '0;
      r_accDeath <= '0;
    end else if (w_accept) begin
      r_snapCur  <= PAD_W'(i_stateCur);
      r_snapPrev <= PAD_W'(i_statePrev);
      r_chunkIdx <= '0;
      r_accAlive <= '0;
      r_accBirth <= '0;
      r_accDeath <= '0;
    end else if (w_countStep) begin
      r_snapCur  <= r_snapCur >> CHUNK;
      r_snapPrev <= r_snapPrev >> CHUNK;
      r_chunkIdx <= r_chunkIdx + K_W'(1);
      r_accAlive <= r_accAlive + CNT_W'(w_pcAlive);
      r_accBirth <= r_accBirth + CNT_W'(w_pcBirth);
      r_accDeath <= r_accDeath + CNT_W'(w_pcDeath);
    end
  end

  assign w_stableNow = (r_accBirth == '0) && (r_accDeath == '0);

  // A clear in the same cycle as the result update takes priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_done       <= 1'b0;
      r_alives     <= '0;
      r_births     <= '0;
      r_deaths     <= '0;
      r_extinct    <= 1'b0;
      r_stable     <= 1'b0;
      r_stableGens <= '0;
    end else begin
      r_done <= w_finish;
      if (w_finish) begin
        r_alives  <= r_accAlive;
        r_births  <= r_accBirth;
        r_deaths  <= r_accDeath;
        r_extinct <= (r_accAlive == '0);
        r_stable  <= w_stableNow;
      end
      if (i_clear) begin
        r_stableGens <= '0;
      end else if (w_finish) begin
        if (!w_stableNow)                r_stableGens <= '0;
        else if (r_stableGens != STAB_MAX) r_stableGens <= r_stableGens + STAB_W'(1);
      end
    end
  end

  assign o_busy       = (r_state != IDLE);
  assign o_done       = r_done;
  assign o_alives     = r_alives;
  assign o_births     = r_births;
  assign o_deaths     = r_deaths;
  assign o_extinct    = r_extinct;
  assign o_stable     = r_stable;
  assign o_stableGens = r_stableGens;

endmodule

// File: tb/tb_gol_census.sv
// Scoreboard bench for gol_census on an 8x8 board: CHUNK=16 main instance,
// CHUNK=24 instance for the padded last chunk, STAB_W=2 instance for saturation.
`timescale 1ns/1ps
module tb_gol_census;

  typedef struct packed {
    logic [6:0] alives;
    logic [6:0] births;
    logic [6:0] deaths;
    logic       extinct;
    logic       stable;
    logic [7:0] sg;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        startA, startB, startC, clear;
  logic [63:0] curV, prevV;

  logic       busyA, doneA, extinctA, stableA;
  logic [6:0] alivesA, birthsA, deathsA;
  logic [7:0] sgA;
  logic       busyB, doneB, extinctB, stableB;
  logic [6:0] alivesB, birthsB, deathsB;
  logic [7:0] sgB;
  logic       busyC, doneC, extinctC, stableC;
  logic [6:0] alivesC, birthsC, deathsC;
  logic [1:0] sgC;

  exp_t       sb[$];
  logic [7:0] mSgA, mSgB, mSgC;
  int         passCnt = 0;
  int         totalCnt = 0;

  always #5 clk = ~clk;

  gol_census #(.ROWS(8), .COLS(8), .CHUNK(16), .STAB_W(8)) dutA (
    .clk(clk), .rst(rst), .i_start(startA), .i_clear(clear),
    .i_stateCur(curV), .i_statePrev(prevV),
    .o_busy(busyA), .o_done(doneA), .o_alives(alivesA), .o_births(birthsA),
    .o_deaths(deathsA), .o_extinct(extinctA), .o_stable(stableA), .o_stableGens(sgA)
  );

  gol_census #(.ROWS(8), .COLS(8), .CHUNK(24), .STAB_W(8)) dutB (
    .clk(clk), .rst(rst), .i_start(startB), .i_clear(clear),
    .i_stateCur(curV), .i_statePrev(prevV),
    .o_busy(busyB), .o_done(doneB), .o_alives(alivesB), .o_births(birthsB),
    .o_deaths(deathsB), .o_extinct(extinctB), .o_stable(stableB), .o_stableGens(sgB)
  );

  gol_census #(.ROWS(8), .COLS(8), .CHUNK(16), .STAB_W(2)) dutC (
    .clk(clk), .rst(rst), .i_start(startC), .i_clear(clear),
    .i_stateCur(curV), .i_statePrev(prevV),
    .o_busy(busyC), .o_done(doneC), .o_alives(alivesC), .o_births(birthsC),
    .o_deaths(deathsC), .o_extinct(extinctC), .o_stable(stableC), .o_stableGens(sgC)
  );

  function automatic exp_t getA();
    exp_t e;
    e = {alivesA, birthsA, deathsA, extinctA, stableA, sgA};
    return e;
  endfunction

  function automatic exp_t getB();
    exp_t e;
    e = {alivesB, birthsB, deathsB, extinctB, stableB, sgB};
    return e;
  endfunction

  function automatic exp_t getC();
    exp_t e;
    e = {alivesC, birthsC, deathsC, extinctC, stableC, 6'b0, sgC};
    return e;
  endfunction

  function automatic logic doneOf(input int dut);
    return (dut == 0) ? doneA : (dut == 1) ? doneB : doneC;
  endfunction

  function automatic string show(input exp_t e);
    return $sformatf("alives=%0d births=%0d deaths=%0d extinct=%0b stable=%0b stableGens=%0d",
                     e.alives, e.births, e.deaths, e.extinct, e.stable, e.sg);
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  // Drive the board vectors and push the census result they should produce.
  task automatic applyStimulus(input int dut, input logic [63:0] cur, input logic [63:0] prev,
                               input logic clrAtDone);
    exp_t       e;
    logic [7:0] old;
    int         mx;
    curV  = cur;
    prevV = prev;
    old   = (dut == 0) ? mSgA : (dut == 1) ? mSgB : mSgC;
    mx    = (dut == 2) ? 3 : 255;
    e.alives  = 7'($countones(cur));
    e.births  = 7'($countones(cur & ~prev));
    e.deaths  = 7'($countones(~cur & prev));
    e.extinct = (e.alives == 7'd0);
    e.stable  = (e.births == 7'd0) && (e.deaths == 7'd0);
    if (clrAtDone || !e.stable) e.sg = 8'd0;
    else if (int'(old) >= mx)   e.sg = old;
    else                        e.sg = old + 8'd1;
    case (dut)
      0:       mSgA = e.sg;
      1:       mSgB = e.sg;
      default: mSgC = e.sg;
    endcase
    sb.push_back(e);
  endtask

  task automatic waitDone(input int dut, inout int n, input int limit);
    while (doneOf(dut) !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    totalCnt++;
    if (busyA !== 1'b0 || doneA !== 1'b0 || getA() !== '0) begin
      $display("[TB] FAIL reset_A: got busy=%0b done=%0b %s required all zero", busyA, doneA, show(getA()));
    end else passCnt++;
    totalCnt++;
    if (busyB !== 1'b0 || doneB !== 1'b0 || getB() !== '0) begin
      $display("[TB] FAIL reset_B: got busy=%0b done=%0b %s required all zero", busyB, doneB, show(getB()));
    end else passCnt++;
    totalCnt++;
    if (busyC !== 1'b0 || doneC !== 1'b0 || getC() !== '0) begin
      $display("[TB] FAIL reset_C: got busy=%0b done=%0b %s required all zero", busyC, doneC, show(getC()));
    end else passCnt++;
  endtask

  task automatic test_all_ones();
    exp_t e;
    int   n;
    sb.delete();
    applyStimulus(0, '1, '0, 1'b0);
    startA = 1'b1;
    tick();
    n = 0;
    startA = 1'b0;
    totalCnt++;
    if (busyA !== 1'b1) $display("[TB] FAIL allones_busy: got %0b required 1", busyA);
    else passCnt++;
    waitDone(0, n, 20);
    totalCnt++;
    if (doneA !== 1'b1) begin
      $display("[TB] FAIL allones_timeout: done=%0b required 1 within 20 cycles", doneA);
    end else begin
      passCnt++;
      e = sb.pop_front();
      totalCnt++;
      if (getA() !== e) $display("[TB] FAIL allones_result: got %s required %s", show(getA()), show(e));
      else passCnt++;
      totalCnt++;
      if (n !== 5) $display("[TB] FAIL allones_latency: got %0d required 5", n);
      else passCnt++;
      tick();
      totalCnt++;
      if (doneA !== 1'b0 || busyA !== 1'b0 || getA() !== e) begin
        $display("[TB] FAIL allones_hold: got done=%0b busy=%0b %s required done=0 busy=0 %s",
                 doneA, busyA, show(getA()), show(e));
      end else passCnt++;
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   n;
    sb.delete();
    for (int i = 0; i < 3; i++) applyStimulus(0, 64'h7, 64'h7, 1'b0);
    startA = 1'b1;
    tick();
    n = 0;
    for (int i = 0; i < 3; i++) begin
      waitDone(0, n, n + 10);
      if (i == 2) startA = 1'b0;
      totalCnt++;
      if (doneA !== 1'b1 || n !== 5 + 6 * i) begin
        $display("[TB] FAIL b2b_timing_%0d: got done=%0b at cycle %0d required done=1 at cycle %0d",
                 i, doneA, n, 5 + 6 * i);
      end else passCnt++;
      e = sb.pop_front();
      totalCnt++;
      if (getA() !== e) $display("[TB] FAIL b2b_result_%0d: got %s required %s", i, show(getA()), show(e));
      else passCnt++;
      tick();
      n++;
    end
    startA = 1'b0;
  endtask

  task automatic test_reset_mid_count();
    int seen;
    curV   = 64'hFFFF;
    prevV  = 64'h0;
    startA = 1'b1;
    tick();
    startA = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    totalCnt++;
    if (busyA !== 1'b0 || doneA !== 1'b0 || getA() !== '0) begin
      $display("[TB] FAIL midreset_outputs: got busy=%0b done=%0b %s required all zero",
               busyA, doneA, show(getA()));
    end else passCnt++;
    sb.delete();
    mSgA = 8'd0;
    mSgB = 8'd0;
    mSgC = 8'd0;
    tick();
    rst  = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (doneA === 1'b1 || busyA === 1'b1) seen++;
    end
    totalCnt++;
    if (seen !== 0) $display("[TB] FAIL midreset_quiet: got %0d done/busy cycles required 0", seen);
    else passCnt++;
  endtask

  task automatic test_extinct();
    exp_t e;
    int   n, seen;
    sb.delete();
    applyStimulus(0, 64'h0, 64'hF0, 1'b0);
    startA = 1'b1;
    tick();
    n = 0;
    startA = 1'b0;
    curV  = '1;
    prevV = 64'h0123_4567_89AB_CDEF;
    tick();
    n++;
    startA = 1'b1;
    tick();
    n++;
    startA = 1'b0;
    waitDone(0, n, 20);
    totalCnt++;
    if (doneA !== 1'b1 || n !== 5) begin
      $display("[TB] FAIL extinct_timing: got done=%0b at cycle %0d required done=1 at cycle 5", doneA, n);
    end else passCnt++;
    e = sb.pop_front();
    totalCnt++;
    if (getA() !== e) $display("[TB] FAIL extinct_result: got %s required %s", show(getA()), show(e));
    else passCnt++;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (doneA === 1'b1 || busyA === 1'b1) seen++;
    end
    totalCnt++;
    if (seen !== 0) $display("[TB] FAIL extinct_no_queue: got %0d busy/done cycles required 0", seen);
    else passCnt++;
  endtask

  task automatic test_random_generations();
    logic [63:0] g[5];
    exp_t        e;
    int          n;
    sb.delete();
    for (int i = 0; i < 5; i++) g[i] = {$urandom(), $urandom()};
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, g[i+1], g[i], 1'b0);
      startA = 1'b1;
      tick();
      n = 0;
      startA = 1'b0;
      waitDone(0, n, 20);
      totalCnt++;
      if (doneA !== 1'b1) begin
        $display("[TB] FAIL random_timeout_%0d: done=%0b required 1", i, doneA);
      end else begin
        passCnt++;
        e = sb.pop_front();
        totalCnt++;
        if (getA() !== e) $display("[TB] FAIL random_result_%0d: got %s required %s", i, show(getA()), show(e));
        else passCnt++;
      end
      tick();
    end
  endtask

  task automatic test_non_multiple();
    exp_t        e;
    int          n;
    logic [63:0] pat;
    sb.delete();
    pat = 64'hFFFF_0000_0000_0001;
    for (int t = 0; t < 2; t++) begin
      if (t == 0) applyStimulus(1, '1, '0, 1'b0);
      else        applyStimulus(1, pat, pat, 1'b0);
      startB = 1'b1;
      tick();
      n = 0;
      startB = 1'b0;
      waitDone(1, n, 20);
      totalCnt++;
      if (doneB !== 1'b1 || n !== 4) begin
        $display("[TB] FAIL chunk24_timing_%0d: got done=%0b at cycle %0d required done=1 at cycle 4", t, doneB, n);
      end else passCnt++;
      e = sb.pop_front();
      totalCnt++;
      if (getB() !== e) $display("[TB] FAIL chunk24_result_%0d: got %s required %s", t, show(getB()), show(e));
      else passCnt++;
      tick();
    end
  endtask

  task automatic test_stab_saturate();
    exp_t e;
    int   n;
    sb.delete();
    for (int i = 0; i < 5; i++) applyStimulus(2, 64'hA5, 64'hA5, 1'b0);
    startC = 1'b1;
    tick();
    n = 0;
    for (int i = 0; i < 5; i++) begin
      waitDone(2, n, n + 10);
      if (i == 4) startC = 1'b0;
      totalCnt++;
      if (doneC !== 1'b1 || n !== 5 + 6 * i) begin
        $display("[TB] FAIL stab_timing_%0d: got done=%0b at cycle %0d required done=1 at cycle %0d",
                 i, doneC, n, 5 + 6 * i);
      end else passCnt++;
      e = sb.pop_front();
      totalCnt++;
      if (getC() !== e) $display("[TB] FAIL stab_result_%0d: got %s required %s", i, show(getC()), show(e));
      else passCnt++;
      tick();
      n++;
    end
    startC = 1'b0;

    // Clear lands on the DONE cycle of an otherwise stable census.
    applyStimulus(2, 64'hA5, 64'hA5, 1'b1);
    startC = 1'b1;
    tick();
    n = 0;
    startC = 1'b0;
    while (n < 4) begin
      tick();
      n++;
    end
    totalCnt++;
    if (busyC !== 1'b1 || doneC !== 1'b0) begin
      $display("[TB] FAIL stab_done_cycle: got busy=%0b done=%0b required busy=1 done=0", busyC, doneC);
    end else passCnt++;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    e = sb.pop_front();
    totalCnt++;
    if (doneC !== 1'b1 || getC() !== e) begin
      $display("[TB] FAIL stab_clear: got done=%0b %s required done=1 %s", doneC, show(getC()), show(e));
    end else passCnt++;
    tick();

    applyStimulus(2, 64'h1A5, 64'hA5, 1'b0);
    startC = 1'b1;
    tick();
    n = 0;
    startC = 1'b0;
    waitDone(2, n, 20);
    e = sb.pop_front();
    totalCnt++;
    if (doneC !== 1'b1 || getC() !== e) begin
      $display("[TB] FAIL stab_birth: got done=%0b %s required done=1 %s", doneC, show(getC()), show(e));
    end else passCnt++;
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached before end of tests");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst    = 1'b1;
    startA = 1'b0;
    startB = 1'b0;
    startC = 1'b0;
    clear  = 1'b0;
    curV   = '0;
    prevV  = '0;
    mSgA   = 8'd0;
    mSgB   = 8'd0;
    mSgC   = 8'd0;
    tick();
    rst = 1'b0;
    tick();
    tick();
    test_reset();
    rst = 1'b1;
    tick();
    test_all_ones();
    test_back_to_back();
    test_reset_mid_count();
    test_extinct();
    test_random_generations();
    test_non_multiple();
    test_stab_saturate();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
